// File: rtl/reg_bank_pkg.sv
// Shared types for the register bank: opcode encoding and the SWAP sequencing states.
package reg_bank_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_CLR  = 3'd6,
    OP_SWAP = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWAP2 = 1'b1
  } state_e;

endpackage

// File: rtl/reg_bank_alu.sv
// Combinational next-value and carry computation for a single register update.
module reg_bank_alu
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] old_val,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] new_val,
  output logic             carry_out,
  output logic             carry_we
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    new_val   = old_val;
    carry_out = 1'b0;
    carry_we  = 1'b0;
    unique case (op)
      OP_LOAD: new_val = load_val;
      OP_INC: begin
        new_val   = old_val + ONE;
        carry_out = &old_val;
        carry_we  = 1'b1;
      end
      OP_DEC: begin
        new_val   = old_val - ONE;
        carry_out = ~|old_val;
        carry_we  = 1'b1;
      end
      OP_SHL: begin
        new_val   = {old_val[WIDTH-2:0], 1'b0};
        carry_out = old_val[WIDTH-1];
        carry_we  = 1'b1;
      end
      OP_SHR: begin
        new_val   = {1'b0, old_val[WIDTH-1:1]};
        carry_out = old_val[0];
        carry_we  = 1'b1;
      end
      OP_CLR:  new_val = '0;
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Small register bank with in-place arithmetic ops and a two-cycle SWAP.
// Define REG_BANK_BYPASS_EN to forward same-cycle LOAD data onto the read ports.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    wa,
  input  logic [AW-1:0]    sa,
  input  logic [WIDTH-1:0] bus,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  output logic             zero0,
  output logic             carry,
  output logic             op_ready
);

  function automatic logic in_range(input logic [AW-1:0] idx);
    return int'(idx) < DEPTH;
  endfunction

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] tmp_q;
  logic [AW-1:0]    sa_q;
  logic             carry_q;
  state_e           state_q, state_d;

  op_e              op_cur;
  logic             accept, wa_ok;
  logic [WIDTH-1:0] old_wa, old_sa;
  logic [WIDTH-1:0] alu_val;
  logic             alu_carry, alu_carry_we;

  assign op_cur   = op_e'(op);
  assign op_ready = (state_q == IDLE);
  assign accept   = op_valid && op_ready;
  assign wa_ok    = in_range(wa);
  assign old_wa   = wa_ok ? regs[wa] : '0;
  assign old_sa   = in_range(sa) ? regs[sa] : '0;
  assign carry    = carry_q;

  reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .op        (op_cur),
    .old_val   (old_wa),
    .load_val  (bus),
    .new_val   (alu_val),
    .carry_out (alu_carry),
    .carry_we  (alu_carry_we)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && op_cur == OP_SWAP) state_d = SWAP2;
      SWAP2:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the register array is reset entry by entry so an aborted SWAP leaves nothing behind.
  // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      tmp_q   <= '0;
      sa_q    <= '0;
      carry_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
      if (state_q == SWAP2) begin
        if (in_range(sa_q)) regs[sa_q] <= tmp_q;
      end else if (accept) begin
        if (op_cur == OP_SWAP) begin
          tmp_q <= old_wa;
          sa_q  <= sa;
          if (wa_ok) regs[wa] <= old_sa;
        end else if (wa_ok) begin
          regs[wa] <= alu_val;
        end
        if (alu_carry_we) carry_q <= alu_carry;
      end
    end
  end

  // Reads see the array before this cycle's write unless bypass forwards a LOAD.
  always_comb begin
    rd0 = in_range(ra0) ? regs[ra0] : '0;
    rd1 = in_range(ra1) ? regs[ra1] : '0;
`ifdef REG_BANK_BYPASS_EN
    if (accept && op_cur == OP_LOAD && wa_ok) begin
      if (ra0 == wa) rd0 = bus;
      if (ra1 == wa) rd1 = bus;
    end
`else
`endif
    zero0 = (rd0 == '0);
  end

endmodule
